// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner (Pmod KYPD).
// Drives one active-low column at a time, samples the synchronized active-low
// rows at the end of each column dwell, classifies each full sweep, debounces
// the classification and emits a hex key code with a one-cycle strobe.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat strobes while held).
module keypad_scan #(
  parameter int SCAN_DIV      = 1 << 17,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_SWEEPS = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

  logic [3:0]    rows_meta, rows_sync;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    col;
  logic          tick, sweep_end;
  logic [11:0]   snap;        // columns 0..2; column 3 is taken live at sweep end
  logic [15:0]   pressed;     // bit c*4+r, active-high
  logic [4:0]    n_pressed;
  cls_t          cur_kind, prev_kind;
  logic [3:0]    cur_code, prev_code;
  logic [SW-1:0] stab_cnt, stab_next;
  logic          same_cls, accept, rep_fire;

  // Map snapshot bit index {col,row} to the printed key legend.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
      4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
      4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
      4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
      4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
      4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
      4'd14: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick      = (pre_cnt == PW'(SCAN_DIV - 1));
  assign sweep_end = tick && (col == 2'd3);
  assign cols      = ~(4'b0001 << col);

  // Two-flop synchronizer for the asynchronous row pins (idle = all high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  // Dwell prescaler, column pointer and per-column row snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      col     <= 2'd0;
      snap    <= 12'hFFF;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        col <= col + 2'd1;
        case (col)
          2'd0:    snap[3:0]  <= rows_sync;
          2'd1:    snap[7:4]  <= rows_sync;
          2'd2:    snap[11:8] <= rows_sync;
          default: ;
        endcase
      end
    end
  end

  // Classify the completed sweep: none, exactly one key, or several keys.
  always_comb begin
    pressed   = ~{rows_sync, snap};
    n_pressed = 5'd0;
    cur_code  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n_pressed = n_pressed + 5'd1;
        cur_code  = key_map(4'(i));
      end
    end
    if (n_pressed == 5'd0) begin
      cur_kind = CLS_NONE;
    end else if (n_pressed == 5'd1) begin
      cur_kind = CLS_SINGLE;
    end else begin
      cur_kind = CLS_MULTI;
      cur_code = 4'h0;
    end
  end

  // Stability count; acceptance fires only on the sweep that reaches DEBOUNCE.
  always_comb begin
    same_cls = (cur_kind == prev_kind) && (cur_code == prev_code);
    if (!same_cls)
      stab_next = SW'(1);
    else if (stab_cnt == SW'(DEBOUNCE))
      stab_next = stab_cnt;
    else
      stab_next = stab_cnt + SW'(1);
    accept = (stab_next == SW'(DEBOUNCE)) && !(same_cls && (stab_cnt == SW'(DEBOUNCE)));
  end

  // Debounce history and accepted key state; strobe is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_kind <= CLS_NONE;
      prev_code <= 4'h0;
      stab_cnt  <= '0;
      key_code  <= 4'h0;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= rep_fire;
      if (sweep_end) begin
        prev_kind <= cur_kind;
        prev_code <= cur_code;
        stab_cnt  <= stab_next;
        if (accept) begin
          if (cur_kind == CLS_SINGLE) begin
            if ((cur_code != key_code) || !key_down) begin
              key_code  <= cur_code;
              key_down  <= 1'b1;
              key_valid <= 1'b1;
            end
          end else if (cur_kind == CLS_NONE) begin
            key_down <= 1'b0;
          end
        end
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SWEEPS + 1);
  logic [RW-1:0] rep_cnt;
  logic          hold_match;

  assign hold_match = key_down && (cur_kind == CLS_SINGLE) && (cur_code == key_code);
  assign rep_fire   = sweep_end && !accept && hold_match && (rep_cnt == RW'(REPEAT_SWEEPS - 1));

  // Count held sweeps after acceptance; wrap on each repeat strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if (sweep_end) begin
      if (accept || !hold_match || rep_fire)
        rep_cnt <= '0;
      else
        rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  // Repeat disabled: the comparison is constant false and only consumes the parameter.
  assign rep_fire = (REPEAT_SWEEPS < 0);
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a behavioural 4x4 keypad.
module tb_keypad_scan;

  localparam int SWEEP = 16;  // 4 columns x SCAN_DIV(4)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // Key bits indexed col*4+row.
  localparam logic [15:0] K1 = 16'h0001 << 0;   // r0 c0
  localparam logic [15:0] K7 = 16'h0001 << 2;   // r2 c0
  localparam logic [15:0] K2 = 16'h0001 << 4;   // r0 c1
  localparam logic [15:0] K5 = 16'h0001 << 5;   // r1 c1
  localparam logic [15:0] K3 = 16'h0001 << 8;   // r0 c2
  localparam logic [15:0] K9 = 16'h0001 << 10;  // r2 c2
  localparam logic [15:0] KD = 16'h0001 << 15;  // r3 c3

  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int double_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2), .REPEAT_SWEEPS(4)) dut (
    .clk(clk), .reset_n(reset_n), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  // Clock.
  always #5 clk = ~clk;

  // Keypad model: a row reads low when a pressed key sits in the driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[c*4+r] && !cols[c]) rows[r] = 1'b0;
  end

  // Strobe monitor: total strobes and back-to-back strobes.
  always @(posedge clk) begin
    if (key_valid) valid_cnt++;
    if (key_valid && prev_valid) double_cnt++;
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a strobe; returns at the negedge where it is visible.
  task automatic wait_valid(input int max_cyc, output logic found);
    found = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (key_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic       found;
    logic [3:0] exp_cols;
    int         base;

    // 1: reset values, then column stepping every 4 clocks.
    cycles(10);
    check("rst_cols", cols, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      exp_cols = ~(4'b0001 << ((i / 4) % 4));
      check("cols_step", cols, exp_cols);
      @(negedge clk);
    end

    // 2: hold '5'; one strobe within 3 sweeps + 2 clocks.
    base = valid_cnt;
    keys = K5;
    wait_valid(3*SWEEP + 2, found);
    check("t2_found", found, 1'b1);
    check("t2_code", key_code, 4'h5);
    check("t2_down", key_down, 1'b1);
    cycles(20*SWEEP);
`ifndef KEYPAD_REPEAT_EN
    check("t2_one_strobe", valid_cnt - base, 1);
`endif

    // Release '5': key_down drops, code holds.
    keys = 16'h0000;
    cycles(4*SWEEP);
    check("rel5_down", key_down, 1'b0);
    check("rel5_code", key_code, 4'h5);

    // 3: '7' for one sweep only.
    base = valid_cnt;
    keys = K7;
    cycles(SWEEP);
    keys = 16'h0000;
    cycles(4*SWEEP);
    check("t3_no_strobe", valid_cnt - base, 0);
    check("t3_down", key_down, 1'b0);

    // 4: '1' and '2' together (ghost reject).
    base = valid_cnt;
    keys = K1 | K2;
    cycles(10*SWEEP);
    check("t4_no_strobe", valid_cnt - base, 0);
    check("t4_down", key_down, 1'b0);
    check("t4_code", key_code, 4'h5);
    keys = 16'h0000;
    cycles(4*SWEEP);

    // 5: press 'D', then roll to '3' with overlap.
    base = valid_cnt;
    keys = KD;
    wait_valid(3*SWEEP + 2, found);
    check("t5d_found", found, 1'b1);
    check("t5d_code", key_code, 4'hD);
    cycles(1);
    check("t5d_one", valid_cnt - base, 1);
    cycles(2*SWEEP);
    base = valid_cnt;
    keys = KD | K3;
    cycles(SWEEP);
    keys = K3;
    wait_valid(4*SWEEP, found);
    check("t5r_found", found, 1'b1);
    check("t5r_code", key_code, 4'h3);
    check("t5r_down", key_down, 1'b1);
    cycles(2*SWEEP);
    check("t5r_one", valid_cnt - base, 1);

    // 6: reset pulse while '9' held.
    keys = K9;
    cycles(4*SWEEP);
    reset_n = 1'b0;
    cycles(3);
    check("t6_rst_cols", cols, 4'b1110);
    check("t6_rst_code", key_code, 4'h0);
    check("t6_rst_down", key_down, 1'b0);
    check("t6_rst_valid", key_valid, 1'b0);
    reset_n = 1'b1;
    wait_valid(3*SWEEP + 2, found);
    check("t6_found", found, 1'b1);
    check("t6_code", key_code, 4'h9);
    check("t6_down", key_down, 1'b1);
    cycles(1);
    base = valid_cnt;
    cycles(12*SWEEP + 8);
`ifdef KEYPAD_REPEAT_EN
    check("t6_repeats", valid_cnt - base, 3);
`else
    check("t6_no_repeat", valid_cnt - base, 0);
`endif
    check("t6_code_hold", key_code, 4'h9);
    keys = 16'h0000;
    cycles(4*SWEEP);
    check("t6_release", key_down, 1'b0);

    check("no_double_strobe", double_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
